// File: rtl/ecc_scalar_mult_ctrl_if.sv
// Command channel between the scalar-multiplication sequencer and the shared GF point-op unit.
// A command is accepted on op_valid & op_ready; op_done pulses once when that command completes.
interface ecc_scalar_mult_ctrl_if;
   logic op_valid;
   logic op_add;
   logic op_ready;
   logic op_done;

   modport master (output op_valid, output op_add, input op_ready, input op_done);
   modport slave  (input op_valid, input op_add, output op_ready, output op_done);
endinterface

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for kP: scans k from MSB to LSB and issues DBL/ADD
// commands to the point-op unit, one outstanding at a time. All outputs are decoded from registers.
module ecc_scalar_mult_ctrl #(
   parameter  int K_WIDTH = 4,
   localparam int IDX_W   = $clog2(K_WIDTH)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [K_WIDTH-1:0]       i_k,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_inf,
   output logic                     o_load_p,
   output logic [IDX_W-1:0]         o_bit_idx,
   ecc_scalar_mult_ctrl_if.master   op_bus
);

   typedef enum logic [2:0] {
      IDLE, SCAN, LOAD, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [K_WIDTH-1:0] r_k, w_k_nxt;
   logic               r_inf, w_inf_nxt;

   logic               w_bit;
   logic               w_idx_zero;
   logic [IDX_W-1:0]   w_idx_dec;

   assign w_bit      = r_k[r_idx];
   assign w_idx_zero = (r_idx == '0);
   assign w_idx_dec  = r_idx - IDX_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_k     <= '0;
         r_inf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_k     <= w_k_nxt;
         r_inf   <= w_inf_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_k_nxt     = r_k;
      w_inf_nxt   = r_inf;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_k_nxt     = i_k;
               w_idx_nxt   = IDX_W'(K_WIDTH - 1);
               w_inf_nxt   = 1'b0;
               w_state_nxt = SCAN;
            end
         end
         // R is still infinity here, so leading zeros cost one cycle each and no DBL
         SCAN: begin
            if (w_bit) begin
               w_state_nxt = LOAD;
            end else if (w_idx_zero) begin
               w_inf_nxt   = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_idx_nxt   = w_idx_dec;
            end
         end
         LOAD: begin
            if (w_idx_zero) begin
               w_state_nxt = DONE;
            end else begin
               w_idx_nxt   = w_idx_dec;
               w_state_nxt = DBL_REQ;
            end
         end
         DBL_REQ: begin
            if (op_bus.op_ready) w_state_nxt = DBL_WAIT;
         end
         DBL_WAIT: begin
            if (op_bus.op_done) begin
               if (w_bit) begin
                  w_state_nxt = ADD_REQ;
               end else if (w_idx_zero) begin
                  w_state_nxt = DONE;
               end else begin
                  w_idx_nxt   = w_idx_dec;
                  w_state_nxt = DBL_REQ;
               end
            end
         end
         ADD_REQ: begin
            if (op_bus.op_ready) w_state_nxt = ADD_WAIT;
         end
         ADD_WAIT: begin
            if (op_bus.op_done) begin
               if (w_idx_zero) begin
                  w_state_nxt = DONE;
               end else begin
                  w_idx_nxt   = w_idx_dec;
                  w_state_nxt = DBL_REQ;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_busy          = (r_state != IDLE);
   assign o_done          = (r_state == DONE);
   assign o_inf           = r_inf;
   assign o_load_p        = (r_state == LOAD);
   assign o_bit_idx       = r_idx;
   assign op_bus.op_valid = (r_state == DBL_REQ) || (r_state == ADD_REQ);
   assign op_bus.op_add   = (r_state == ADD_REQ);

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Directed bench for the kP sequencer: a point-op unit model answers commands and a scoreboard
// queue holds the DBL/ADD sequence each scalar should produce.
module tb_ecc_scalar_mult_ctrl;
   localparam int KW = 4;
   localparam int IW = $clog2(KW);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [KW-1:0] k;
   logic          busy, done, inf, load_p;
   logic [IW-1:0] bit_idx;

   ecc_scalar_mult_ctrl_if bus ();

   ecc_scalar_mult_ctrl #(.K_WIDTH(KW)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_k       (k),
      .o_busy    (busy),
      .o_done    (done),
      .o_inf     (inf),
      .o_load_p  (load_p),
      .o_bit_idx (bit_idx),
      .op_bus    (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Point-op unit model: ready after stall_n cycles of valid, done pulse 2 cycles after accept
   int   stall_n = 0;
   int   vcnt;
   int   dly;
   assign bus.op_ready = (vcnt >= stall_n);
   assign bus.op_done  = (dly == 1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vcnt <= 0;
         dly  <= 0;
      end else begin
         if (bus.op_valid && bus.op_ready) vcnt <= 0;
         else if (bus.op_valid)            vcnt <= vcnt + 1;
         if (bus.op_valid && bus.op_ready) dly <= 2;
         else if (dly != 0)                dly <= dly - 1;
      end
   end

   // Scoreboard and handshake monitor, sampled on the falling edge
   logic exp_q[$];
   int   load_cnt, done_cnt, load_idx;
   logic outstanding, pending, pend_add;

   always @(negedge clk) begin
      if (!rst_n) begin
         outstanding = 1'b0;
         pending     = 1'b0;
      end else begin
         if (pending) begin
            check("valid_held", {31'd0, bus.op_valid}, 32'd1);
            check("add_stable", {31'd0, bus.op_add}, {31'd0, pend_add});
         end
         if (bus.op_valid) check("one_outstanding", {31'd0, outstanding}, 32'd0);
         if (bus.op_done) outstanding = 1'b0;
         if (bus.op_valid && bus.op_ready) begin
            if (exp_q.size() == 0) check("cmd_extra", 32'd1, 32'd0);
            else check("cmd_type", {31'd0, bus.op_add}, {31'd0, exp_q.pop_front()});
            outstanding = 1'b1;
         end
         pending  = bus.op_valid && !bus.op_ready;
         pend_add = bus.op_add;
         if (load_p) begin
            load_cnt++;
            load_idx = int'(bit_idx);
         end
         if (done) done_cnt++;
      end
   end

   task automatic push_exp(input logic [KW-1:0] kv);
      int msb = -1;
      for (int i = KW - 1; i >= 0; i--) if (kv[i] && msb < 0) msb = i;
      for (int i = msb - 1; i >= 0; i--) begin
         exp_q.push_back(1'b0);
         if (kv[i]) exp_q.push_back(1'b1);
      end
   endtask

   task automatic start_k(input logic [KW-1:0] kv, input int stall);
      load_cnt = 0;
      done_cnt = 0;
      load_idx = -1;
      stall_n  = stall;
      push_exp(kv);
      @(negedge clk);
      k     = kv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("inf_cleared", {31'd0, inf}, 32'd0);
      check("busy_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic finish_k(input logic exp_inf, input int exp_load, input int exp_cyc);
      int cyc = 1;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      if (exp_cyc > 0) check("done_latency", cyc, exp_cyc);
      @(negedge clk);
      check("done_count", done_cnt, 32'd1);
      check("done_pulse", {31'd0, done}, 32'd0);
      check("busy_end", {31'd0, busy}, 32'd0);
      check("load_count", load_cnt, exp_load);
      check("inf", {31'd0, inf}, {31'd0, exp_inf});
      check("cmds_left", exp_q.size(), 32'd0);
   endtask

   initial begin
      int hit;
      rst_n = 1'b0;
      start = 1'b0;
      k     = '0;
      repeat (3) @(negedge clk);
      check("reset_outs", {25'd0, busy, done, inf, load_p, bus.op_valid, bus.op_add, bit_idx},
            32'd0);
      rst_n = 1'b1;

      start_k(4'b1011, 0);
      finish_k(1'b0, 1, 0);

      start_k(4'b0000, 0);
      finish_k(1'b1, 0, 5);
      repeat (3) @(negedge clk);
      check("inf_held", {31'd0, inf}, 32'd1);

      start_k(4'b0001, 0);
      finish_k(1'b0, 1, 6);
      check("load_idx", load_idx, 32'd0);

      start_k(4'b1000, 3);
      finish_k(1'b0, 1, 0);

      // Restart attempt and k change mid-run must not disturb the latched scalar
      start_k(4'b1101, 0);
      repeat (2) @(negedge clk);
      k     = 4'b0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k     = 4'b0111;
      check("busy_mid", {31'd0, busy}, 32'd1);
      finish_k(1'b0, 1, 0);

      // Asynchronous reset while a DBL is outstanding
      start_k(4'b1011, 0);
      hit = 0;
      for (int i = 0; i < 50 && hit == 0; i++) begin
         @(negedge clk);
         if (outstanding && !bus.op_valid) hit = 1;
      end
      check("reached_wait", hit, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outs",
            {25'd0, busy, done, inf, load_p, bus.op_valid, bus.op_add, bit_idx}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("no_done_abort", done_cnt, 32'd0);
      rst_n = 1'b1;

      start_k(4'b0110, 0);
      finish_k(1'b0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
